// File: rtl/toaplan2_csync_gen_pkg.sv
// Toaplan2 raster timing constants, pattern encodings and the shared video-beat type
// used by the composite-sync test-pattern generator.
package toaplan2_csync_gen_pkg;

    // Raster geometry in pixel clocks / lines (pixel clock = PCLK2x / 2).
    localparam int unsigned TP2_H_TOTAL     = 432;
    localparam int unsigned TP2_H_SYNCLEN   = 32;
    localparam int unsigned TP2_H_BACKPORCH = 55;
    localparam int unsigned TP2_H_ACTIVE    = 320;
    localparam int unsigned TP2_V_TOTAL     = 263;
    localparam int unsigned TP2_V_SYNCLEN   = 3;
    localparam int unsigned TP2_V_BACKPORCH = 18;
    localparam int unsigned TP2_V_ACTIVE    = 240;

    localparam int unsigned TP2_BAR_WIDTH   = 40;
    localparam int unsigned TP2_GRID_PITCH  = 32;
    localparam logic [4:0]  TP2_LEVEL_FULL  = 5'd31;

    typedef enum logic [1:0] {
        TP2_PAT_BARS     = 2'd0,
        TP2_PAT_GRID     = 2'd1,
        TP2_PAT_GRADIENT = 2'd2,
        TP2_PAT_CHECKER  = 2'd3
    } tp2_pattern_e;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } tp2_rgb_t;

    typedef struct packed {
        tp2_rgb_t   rgb;
        logic       csync_n;
        logic       hsync_n;
        logic       vsync_n;
        logic       de;
        logic [8:0] xpos;
        logic [8:0] ypos;
        logic       frame_change;
    } tp2_video_t;

    // What the output stage shows while in reset or while the generator is idle.
    localparam tp2_video_t TP2_VIDEO_IDLE = '{
        rgb:          '0,
        csync_n:      1'b1,
        hsync_n:      1'b1,
        vsync_n:      1'b1,
        de:           1'b0,
        xpos:         '0,
        ypos:         '0,
        frame_change: 1'b0
    };

    function automatic tp2_rgb_t tp2_mono(input logic on);
        tp2_rgb_t c;
        c.r = on ? TP2_LEVEL_FULL : 5'd0;
        c.g = on ? TP2_LEVEL_FULL : 5'd0;
        c.b = on ? TP2_LEVEL_FULL : 5'd0;
        return c;
    endfunction

    function automatic logic tp2_in_span(input logic [8:0] c,
                                         input logic [8:0] lo,
                                         input logic [8:0] hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/tp2_pattern_rom.sv
// Combinational test-pattern lookup: active-area coordinate, frame parity and
// pattern select in, 5-bit RGB out. Shared by the board timing generators.
module tp2_pattern_rom
    import toaplan2_csync_gen_pkg::*;
(
    input  logic [8:0]   x,
    input  logic [8:0]   y,
    input  logic         parity,
    input  tp2_pattern_e sel,
    output tp2_rgb_t     rgb
);

    logic [2:0] bar;
    logic       on_grid;

    always_comb begin
        bar     = 3'(x / 9'(TP2_BAR_WIDTH));
        on_grid = ((x % 9'(TP2_GRID_PITCH)) == 9'd0) ||
                  ((y % 9'(TP2_GRID_PITCH)) == 9'd0);
        rgb     = '0;
        case (sel)
            TP2_PAT_BARS: begin
                rgb.r = bar[2] ? TP2_LEVEL_FULL : 5'd0;
                rgb.g = bar[1] ? TP2_LEVEL_FULL : 5'd0;
                rgb.b = bar[0] ? TP2_LEVEL_FULL : 5'd0;
            end
            TP2_PAT_GRID: begin
                rgb = tp2_mono(on_grid);
            end
            TP2_PAT_GRADIENT: begin
                rgb.r = x[8:4];
                rgb.g = x[8:4];
                rgb.b = x[8:4];
            end
            TP2_PAT_CHECKER: begin
                // Parity flips the phase every frame so the checker visibly alternates.
                rgb = tp2_mono(x[3] ^ y[3] ^ parity);
            end
            default: begin
                rgb = '0;
            end
        endcase
    end

endmodule

// File: rtl/toaplan2_csync_gen.sv
// Toaplan2-format composite-sync timing and test-pattern source running at half
// the PCLK2x rate, with separated syncs, DE and active-area coordinates alongside.
module toaplan2_csync_gen
    import toaplan2_csync_gen_pkg::*;
#(
    parameter int unsigned H_TOTAL     = TP2_H_TOTAL,
    parameter int unsigned H_SYNCLEN   = TP2_H_SYNCLEN,
    parameter int unsigned H_BACKPORCH = TP2_H_BACKPORCH,
    parameter int unsigned H_ACTIVE    = TP2_H_ACTIVE,
    parameter int unsigned V_TOTAL     = TP2_V_TOTAL,
    parameter int unsigned V_SYNCLEN   = TP2_V_SYNCLEN,
    parameter int unsigned V_BACKPORCH = TP2_V_BACKPORCH,
    parameter int unsigned V_ACTIVE    = TP2_V_ACTIVE
) (
    input  logic       PCLK2x_i,
    input  logic       reset_n,
    input  logic       enable_i,
    input  logic [1:0] pattern_sel_i,
    output logic [4:0] R_o,
    output logic [4:0] G_o,
    output logic [4:0] B_o,
    output logic       CSYNC_o,
    output logic       HSYNC_o,
    output logic       VSYNC_o,
    output logic       DE_o,
    output logic [8:0] xpos,
    output logic [8:0] ypos,
    output logic       frame_change
);

    localparam logic [8:0] H_LAST      = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_SYNC_END  = 9'(H_SYNCLEN);
    localparam logic [8:0] V_SYNC_END  = 9'(V_SYNCLEN);
    localparam logic [8:0] H_ACT_START = 9'(H_SYNCLEN + H_BACKPORCH);
    localparam logic [8:0] H_ACT_END   = 9'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
    localparam logic [8:0] V_ACT_START = 9'(V_SYNCLEN + V_BACKPORCH);
    localparam logic [8:0] V_ACT_END   = 9'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);

    logic         divctr;
    logic [8:0]   h_ctr;
    logic [8:0]   v_ctr;
    logic         parity;
    tp2_pattern_e pat_q;

    logic         h_wrap;
    logic         v_wrap;

    assign h_wrap = divctr && (h_ctr == H_LAST);
    assign v_wrap = h_wrap && (v_ctr == V_LAST);

    // Raster counters. Parity and the latched pattern survive an idle period;
    // only the position restarts from the top-left corner.
    always_ff @(posedge PCLK2x_i or negedge reset_n) begin
        if (!reset_n) begin
            divctr <= 1'b0;
            h_ctr  <= '0;
            v_ctr  <= '0;
            parity <= 1'b0;
            pat_q  <= TP2_PAT_BARS;
        end else if (!enable_i) begin
            divctr <= 1'b0;
            h_ctr  <= '0;
            v_ctr  <= '0;
        end else begin
            divctr <= ~divctr;
            if (divctr) begin
                h_ctr <= h_wrap ? 9'd0 : h_ctr + 9'd1;
            end
            if (h_wrap) begin
                v_ctr <= v_wrap ? 9'd0 : v_ctr + 9'd1;
            end
            if (v_wrap) begin
                parity <= ~parity;
                pat_q  <= tp2_pattern_e'(pattern_sel_i);
            end
        end
    end

    logic       h_sync_act;
    logic       v_sync_act;
    logic       de_c;
    logic [8:0] x_c;
    logic [8:0] y_c;
    tp2_rgb_t   pat_rgb;
    tp2_video_t vid_d;
    tp2_video_t vid_q;

    always_comb begin
        h_sync_act = h_ctr < H_SYNC_END;
        v_sync_act = v_ctr < V_SYNC_END;
        de_c       = tp2_in_span(h_ctr, H_ACT_START, H_ACT_END) &&
                     tp2_in_span(v_ctr, V_ACT_START, V_ACT_END);
        x_c        = de_c ? (h_ctr - H_ACT_START) : 9'd0;
        y_c        = de_c ? (v_ctr - V_ACT_START) : 9'd0;
    end

    tp2_pattern_rom u_pattern_rom (
        .x      (x_c),
        .y      (y_c),
        .parity (parity),
        .sel    (pat_q),
        .rgb    (pat_rgb)
    );

    always_comb begin
        vid_d              = TP2_VIDEO_IDLE;
        vid_d.rgb          = de_c ? pat_rgb : '0;
        vid_d.hsync_n      = ~h_sync_act;
        vid_d.vsync_n      = ~v_sync_act;
        // No serration: the whole vsync line is held low.
        vid_d.csync_n      = v_sync_act ? 1'b0 : ~h_sync_act;
        vid_d.de           = de_c;
        vid_d.xpos         = x_c;
        vid_d.ypos         = y_c;
        vid_d.frame_change = (v_ctr == 9'd0);
    end

    always_ff @(posedge PCLK2x_i or negedge reset_n) begin
        if (!reset_n) begin
            vid_q <= TP2_VIDEO_IDLE;
        end else if (!enable_i) begin
            vid_q <= TP2_VIDEO_IDLE;
        end else begin
            vid_q <= vid_d;
        end
    end

    assign R_o          = vid_q.rgb.r;
    assign G_o          = vid_q.rgb.g;
    assign B_o          = vid_q.rgb.b;
    assign CSYNC_o      = vid_q.csync_n;
    assign HSYNC_o      = vid_q.hsync_n;
    assign VSYNC_o      = vid_q.vsync_n;
    assign DE_o         = vid_q.de;
    assign xpos         = vid_q.xpos;
    assign ypos         = vid_q.ypos;
    assign frame_change = vid_q.frame_change;

endmodule

// File: tb/tb_toaplan2_csync_gen.sv
// Bench for toaplan2_csync_gen: a full-size raster instance and a shrunken one,
// both scored cycle-by-cycle against a raster model derived from the pixel index.
module tb_toaplan2_csync_gen;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
        logic       cs;
        logic       hs;
        logic       vs;
        logic       de;
        logic [8:0] x;
        logic [8:0] y;
        logic       fc;
    } vid_t;

    // Index 0: shrunken raster, index 1: Toaplan2 defaults.
    int p_ht [2] = '{120, 432};
    int p_hs [2] = '{8,   32};
    int p_hb [2] = '{10,  55};
    int p_ha [2] = '{100, 320};
    int p_vt [2] = '{24,  263};
    int p_vs [2] = '{3,   3};
    int p_vb [2] = '{3,   18};
    int p_va [2] = '{16,  240};

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [1:0] sel;

    logic [4:0] s_r, s_g, s_b, f_r, f_g, f_b;
    logic       s_cs, s_hs, s_vs, s_de, s_fc;
    logic       f_cs, f_hs, f_vs, f_de, f_fc;
    logic [8:0] s_x, s_y, f_x, f_y;
    vid_t       s_act, f_act;

    vid_t exp_q_s[$];
    vid_t exp_q_f[$];

    int checks = 0;
    int errors = 0;

    toaplan2_csync_gen #(
        .H_TOTAL(120), .H_SYNCLEN(8), .H_BACKPORCH(10), .H_ACTIVE(100),
        .V_TOTAL(24),  .V_SYNCLEN(3), .V_BACKPORCH(3),  .V_ACTIVE(16)
    ) dut_s (
        .PCLK2x_i      (clk),
        .reset_n       (reset_n),
        .enable_i      (enable),
        .pattern_sel_i (sel),
        .R_o           (s_r),
        .G_o           (s_g),
        .B_o           (s_b),
        .CSYNC_o       (s_cs),
        .HSYNC_o       (s_hs),
        .VSYNC_o       (s_vs),
        .DE_o          (s_de),
        .xpos          (s_x),
        .ypos          (s_y),
        .frame_change  (s_fc)
    );

    toaplan2_csync_gen dut_f (
        .PCLK2x_i      (clk),
        .reset_n       (reset_n),
        .enable_i      (enable),
        .pattern_sel_i (sel),
        .R_o           (f_r),
        .G_o           (f_g),
        .B_o           (f_b),
        .CSYNC_o       (f_cs),
        .HSYNC_o       (f_hs),
        .VSYNC_o       (f_vs),
        .DE_o          (f_de),
        .xpos          (f_x),
        .ypos          (f_y),
        .frame_change  (f_fc)
    );

    assign s_act = {s_r, s_g, s_b, s_cs, s_hs, s_vs, s_de, s_x, s_y, s_fc};
    assign f_act = {f_r, f_g, f_b, f_cs, f_hs, f_vs, f_de, f_x, f_y, f_fc};

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_vid(input string tag, input vid_t a, input vid_t e);
        check({tag, ".R"},     int'(a.r),  int'(e.r));
        check({tag, ".G"},     int'(a.g),  int'(e.g));
        check({tag, ".B"},     int'(a.b),  int'(e.b));
        check({tag, ".CSYNC"}, int'(a.cs), int'(e.cs));
        check({tag, ".HSYNC"}, int'(a.hs), int'(e.hs));
        check({tag, ".VSYNC"}, int'(a.vs), int'(e.vs));
        check({tag, ".DE"},    int'(a.de), int'(e.de));
        check({tag, ".FC"},    int'(a.fc), int'(e.fc));
        if (e.de) begin
            check({tag, ".xpos"}, int'(a.x), int'(e.x));
            check({tag, ".ypos"}, int'(a.y), int'(e.y));
        end
    endtask

    function automatic vid_t idle_vid();
        vid_t e;
        e    = '0;
        e.cs = 1'b1;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // Reference: what the raster should show at pixel (h, v) of a frame.
    function automatic vid_t ref_pixel(input int d, input int h, input int v,
                                       input int pat, input int par);
        vid_t e;
        int   hst, vst, x, y, bar;
        logic on;
        e    = '0;
        hst  = p_hs[d] + p_hb[d];
        vst  = p_vs[d] + p_vb[d];
        e.hs = (h < p_hs[d]) ? 1'b0 : 1'b1;
        e.vs = (v < p_vs[d]) ? 1'b0 : 1'b1;
        e.cs = (v < p_vs[d]) ? 1'b0 : e.hs;
        e.fc = (v == 0);
        e.de = (h >= hst) && (h < hst + p_ha[d]) && (v >= vst) && (v < vst + p_va[d]);
        if (e.de) begin
            x   = h - hst;
            y   = v - vst;
            e.x = 9'(x);
            e.y = 9'(y);
            on  = 1'b0;
            case (pat)
                0: begin
                    bar = x / 40;
                    e.r = (bar >= 4) ? 5'd31 : 5'd0;
                    e.g = (((bar / 2) % 2) == 1) ? 5'd31 : 5'd0;
                    e.b = ((bar % 2) == 1) ? 5'd31 : 5'd0;
                end
                1: begin
                    on  = ((x % 32) == 0) || ((y % 32) == 0);
                    e.r = on ? 5'd31 : 5'd0;
                    e.g = e.r;
                    e.b = e.r;
                end
                2: begin
                    e.r = 5'(x / 16);
                    e.g = e.r;
                    e.b = e.r;
                end
                default: begin
                    on  = (((x / 8) + (y / 8) + par) % 2) == 1;
                    e.r = on ? 5'd31 : 5'd0;
                    e.g = e.r;
                    e.b = e.r;
                end
            endcase
        end
        return e;
    endfunction

    // Reference model: k counts enabled PCLK2x edges since the last restart.
    task automatic model_proc(input int d);
        int   k, pat, par, p, h, v;
        vid_t e;
        k   = 0;
        pat = 0;
        par = 0;
        wait (reset_n === 1'b1);
        forever begin
            @(posedge clk);
            if (enable !== 1'b1) begin
                e = idle_vid();
                k = 0;
            end else begin
                p = k / 2;
                h = p % p_ht[d];
                v = (p / p_ht[d]) % p_vt[d];
                e = ref_pixel(d, h, v, pat, par);
                if ((k % 2) == 1 && h == p_ht[d] - 1 && v == p_vt[d] - 1) begin
                    par = 1 - par;
                    pat = int'(sel);
                end
                k++;
            end
            if (d == 0) exp_q_s.push_back(e);
            else        exp_q_f.push_back(e);
        end
    endtask

    // Monitor: one output beat per PCLK2x edge, sampled 2 time units after it.
    task automatic monitor_proc(input int d);
        vid_t  a, e;
        int    qsz;
        string tag;
        tag = (d == 0) ? "small" : "full";
        wait (reset_n === 1'b1);
        forever begin
            @(posedge clk);
            #2;
            a   = (d == 0) ? s_act : f_act;
            qsz = (d == 0) ? exp_q_s.size() : exp_q_f.size();
            if (qsz == 0) begin
                checks++;
                errors++;
                $display("FAIL %s.queue: got empty expected queue at time %0t", tag, $time);
            end else begin
                e = (d == 0) ? exp_q_s.pop_front() : exp_q_f.pop_front();
                compare_vid(tag, a, e);
            end
        end
    endtask

    initial model_proc(0);
    initial model_proc(1);
    initial monitor_proc(0);
    initial monitor_proc(1);

    // Driver
    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int sel_seq [5] = '{1, 2, 3, 3, 0};
        int cut;
        vid_t idle;
        idle    = idle_vid();
        reset_n = 1'b0;
        enable  = 1'b0;
        sel     = 2'd0;
        run_cycles(4);
        compare_vid("reset_small", s_act, idle);
        compare_vid("reset_full",  f_act, idle);
        check("reset_small.xpos", int'(s_x), 0);
        check("reset_small.ypos", int'(s_y), 0);
        check("reset_full.xpos",  int'(f_x), 0);
        check("reset_full.ypos",  int'(f_y), 0);

        reset_n = 1'b1;
        enable  = 1'b1;
        // Pattern changes land mid-frame; they must only take effect at the wrap.
        for (int f = 0; f < 6; f++) begin
            cut = $urandom_range(100, 5600);
            run_cycles(cut);
            sel = (f < 5) ? 2'(sel_seq[f]) : 2'($urandom_range(0, 3));
            run_cycles(5760 - cut);
        end

        // Enable drops at random points of the line/frame.
        for (int i = 0; i < 6; i++) begin
            run_cycles($urandom_range(500, 6000));
            enable = 1'b0;
            if ($urandom_range(0, 1) == 1) sel = 2'($urandom_range(0, 3));
            run_cycles($urandom_range(1, 4));
            enable = 1'b1;
        end
        run_cycles(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
